// File: rtl/fm_pkg.sv
// Shared types and helpers for the approximate FP multiplier pipeline.
package fm_pkg;

    // Operand special class; zero takes priority over infinity.
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ZERO   = 2'd1,
        INF    = 2'd2
    } fm_class_e;

    // Exponent bias for an exp_w-bit exponent field.
    function automatic int unsigned fm_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

    // Truncated-bit count: exponent magnitude banded by band_shift, capped at max_drop.
    function automatic int unsigned fm_drop_count(input int e_unb,
                                                  input int unsigned band_shift,
                                                  input int unsigned max_drop);
        int unsigned mag;
        mag = (e_unb < 0) ? 32'(-e_unb) : 32'(e_unb);
        mag = mag >> band_shift;
        return (mag > max_drop) ? max_drop : mag;
    endfunction

    // Signed zero encoding, right-aligned in a 64-bit word.
    function automatic logic [63:0] fm_zero_enc(input logic s,
                                                input int unsigned exp_w,
                                                input int unsigned man_w);
        logic [63:0] r;
        r = '0;
        r[exp_w + man_w] = s;
        return r;
    endfunction

    // Signed infinity encoding, right-aligned in a 64-bit word.
    function automatic logic [63:0] fm_inf_enc(input logic s,
                                               input int unsigned exp_w,
                                               input int unsigned man_w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= int'(man_w) && i < int'(man_w + exp_w)) begin
                r[i] = 1'b1;
            end
        end
        r[exp_w + man_w] = s;
        return r;
    endfunction

endpackage

// File: rtl/fm_drop_ctrl.sv
// Precision control: number of low product bits to clear for a given unbiased exponent.
module fm_drop_ctrl
    import fm_pkg::*;
#(
    parameter int unsigned EXP_W      = 8,
    parameter int unsigned BAND_SHIFT = 4,
    parameter int unsigned MAX_DROP   = 7,
    parameter int unsigned DROP_W     = 4
) (
    input  logic [EXP_W+1:0]  e_unb,
    input  logic              approx,
    output logic [DROP_W-1:0] drop_c
);

    // Banded drop when approximation is enabled, otherwise exact.
    always_comb begin
        drop_c = '0;
        if (approx) begin
            drop_c = DROP_W'(fm_drop_count(int'($signed(e_unb)), BAND_SHIFT, MAX_DROP));
        end
    end

endmodule

// File: rtl/fm_approx_pipe.sv
// Three-stage approximate floating-point multiplier with valid/ready flow control.
// Build option: FM_APPROX_SAT_EN saturates overflow to inf and underflow to zero;
// without it the exponent wraps to its low EXP_W bits.
module fm_approx_pipe
    import fm_pkg::*;
#(
    parameter int unsigned EXP_W      = 8,
    parameter int unsigned MAN_W      = 7,
    parameter int unsigned BAND_SHIFT = 4,
    parameter int unsigned MAX_DROP   = MAN_W,
    localparam int unsigned W         = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_approx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_ovf,
    output logic         out_unf
);

    localparam int unsigned EW     = EXP_W + 2;
    localparam int unsigned PW     = 2 * MAN_W + 2;
    localparam int unsigned FW     = MAN_W + 4;
    localparam int unsigned DROP_W = $clog2(MAX_DROP + 2);
    localparam int unsigned BIAS   = fm_bias(EXP_W);

    logic advance;

    // S1 combinational
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [MAN_W-1:0]  ma, mb;
    logic [EW-1:0]     e_unb_c;
    logic [DROP_W-1:0] drop_c;
    fm_class_e         cls_c;

    // S1 registers
    logic              s1_valid, s1_s;
    logic [EW-1:0]     s1_e;
    logic [DROP_W-1:0] s1_drop;
    fm_class_e         s1_cls;
    logic [MAN_W-1:0]  s1_ma, s1_mb;

    // S2 combinational / registers
    logic [PW-1:0]     p_c;
    logic [FW-1:0]     f_c;
    logic              s2_valid, s2_s;
    logic [EW-1:0]     s2_e;
    fm_class_e         s2_cls;
    logic [FW-1:0]     s2_f;

    // S3 combinational
    logic [MAN_W-1:0]  mant_c;
    logic [EW-1:0]     e3_c;
    logic              ovf_c, unf_c;
    logic [W-1:0]      data_c;

    // Whole pipeline moves together unless a result is waiting on the consumer.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // S1: operand split, unbiased exponent and special classification.
    always_comb begin
        sa      = in_a[W-1];
        sb      = in_b[W-1];
        ea      = in_a[W-2 -: EXP_W];
        eb      = in_b[W-2 -: EXP_W];
        ma      = in_a[MAN_W-1:0];
        mb      = in_b[MAN_W-1:0];
        e_unb_c = EW'(ea) + EW'(eb) - EW'(2 * BIAS);
        cls_c   = NORMAL;
        if (ea == '0 || eb == '0) begin
            cls_c = ZERO;
        end else if (ea == '1 || eb == '1) begin
            cls_c = INF;
        end
    end

    fm_drop_ctrl #(
        .EXP_W      (EXP_W),
        .BAND_SHIFT (BAND_SHIFT),
        .MAX_DROP   (MAX_DROP),
        .DROP_W     (DROP_W)
    ) u_drop_ctrl (
        .e_unb  (e_unb_c),
        .approx (in_approx),
        .drop_c (drop_c)
    );

    // S1 stage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_s     <= 1'b0;
            s1_e     <= '0;
            s1_drop  <= '0;
            s1_cls   <= NORMAL;
            s1_ma    <= '0;
            s1_mb    <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_s     <= sa ^ sb;
            s1_e     <= e_unb_c;
            s1_drop  <= drop_c;
            s1_cls   <= cls_c;
            s1_ma    <= ma;
            s1_mb    <= mb;
        end
    end

    // S2: exact significand product, keep the top FW bits, clear the dropped tail.
    always_comb begin
        p_c = PW'({1'b1, s1_ma}) * PW'({1'b1, s1_mb});
        f_c = FW'(p_c >> (MAN_W - 2));
        for (int i = 0; i < int'(FW); i++) begin
            if (i < int'(s1_drop)) begin
                f_c[i] = 1'b0;
            end
        end
    end

    // S2 stage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_s     <= 1'b0;
            s2_e     <= '0;
            s2_cls   <= NORMAL;
            s2_f     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_s     <= s1_s;
            s2_e     <= s1_e;
            s2_cls   <= s1_cls;
            s2_f     <= f_c;
        end
    end

    // S3: normalise by one position at most, truncate, flag range and pack.
    always_comb begin
        if (s2_f[FW-1]) begin
            mant_c = s2_f[FW-2 -: MAN_W];
            e3_c   = s2_e + EW'(BIAS + 1);
        end else begin
            mant_c = s2_f[FW-3 -: MAN_W];
            e3_c   = s2_e + EW'(BIAS);
        end
        ovf_c  = !e3_c[EW-1] && (e3_c >= EW'((32'd1 << EXP_W) - 32'd1));
        unf_c  = e3_c[EW-1] || (e3_c == '0);
        data_c = {s2_s, e3_c[EXP_W-1:0], mant_c};
        case (s2_cls)
            ZERO: begin
                data_c = W'(fm_zero_enc(s2_s, EXP_W, MAN_W));
                ovf_c  = 1'b0;
                unf_c  = 1'b0;
            end
            INF: begin
                data_c = W'(fm_inf_enc(s2_s, EXP_W, MAN_W));
                ovf_c  = 1'b0;
                unf_c  = 1'b0;
            end
            default: begin
`ifdef FM_APPROX_SAT_EN
                if (ovf_c) begin
                    data_c = W'(fm_inf_enc(s2_s, EXP_W, MAN_W));
                end else if (unf_c) begin
                    data_c = W'(fm_zero_enc(s2_s, EXP_W, MAN_W));
                end
`endif
            end
        endcase
    end

    // Output register; holds steady while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_data  <= data_c;
            out_ovf   <= ovf_c;
            out_unf   <= unf_c;
        end
    end

endmodule

// File: tb/tb_fm_approx_pipe.sv
// Directed bench for fm_approx_pipe (bfloat16 defaults).
module tb_fm_approx_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a, in_b;
    logic        in_approx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf, out_unf;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    fm_approx_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_approx (in_approx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    // Hand-computed vectors: a, b, approx -> data, ovf, unf
    logic [15:0] va   [9] = '{16'h3FC0, 16'h77FF, 16'h77FF, 16'h7F00, 16'h8000,
                              16'h7F80, 16'h0000, 16'h0080, 16'hBFC0};
    logic [15:0] vb   [9] = '{16'h4000, 16'h3FFF, 16'h3FFF, 16'h4100, 16'h3F80,
                              16'h4000, 16'h7F80, 16'h0080, 16'h4000};
    logic        vap  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`ifdef FM_APPROX_SAT_EN
    logic [15:0] vexp [9] = '{16'h4040, 16'h7870, 16'h787E, 16'h7F80, 16'h8000,
                              16'h7F80, 16'h0000, 16'h0000, 16'hC040};
`else
    logic [15:0] vexp [9] = '{16'h4040, 16'h7870, 16'h787E, 16'h0080, 16'h8000,
                              16'h7F80, 16'h0000, 16'h4180, 16'hC040};
`endif
    logic        vovf [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vunf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic [17:0] sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one vector into an idle pipe and check latency and result.
    task automatic run_one(input int idx);
        int lat;
        in_valid  = 1'b1;
        in_a      = va[idx];
        in_b      = vb[idx];
        in_approx = vap[idx];
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_eq($sformatf("lat%0d", idx), 32'(lat), 32'd3);
        check_eq($sformatf("data%0d", idx), 32'(out_data), 32'(vexp[idx]));
        check_eq($sformatf("ovf%0d", idx), 32'(out_ovf), 32'(vovf[idx]));
        check_eq($sformatf("unf%0d", idx), 32'(out_unf), 32'(vunf[idx]));
        tick();
    endtask

    initial begin
        int sent, got, extra;
        logic        held;
        logic [15:0] held_data;
        logic [17:0] e;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_approx = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_flags", 32'({out_ovf, out_unf}), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) run_one(i);

        // Backpressure: six back-to-back inputs, consumer stalled in cycles 3..6.
        sent = 0; got = 0; held = 1'b0; held_data = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 6);
            in_a      = va[sent % 9];
            in_b      = vb[sent % 9];
            in_approx = vap[sent % 9];
            #1;
            if (held) check_eq("bp_hold", 32'(out_data), 32'(held_data));
            held = 1'b0;
            if (out_valid && !out_ready) begin
                check_eq("bp_in_ready", 32'(in_ready), 32'd0);
                held = 1'b1;
                held_data = out_data;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({vexp[sent], vovf[sent], vunf[sent]});
                sent++;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("bp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq($sformatf("bp_out%0d", got), 32'({out_data, out_ovf, out_unf}), 32'(e));
                end
                got++;
            end
            tick();
        end
        in_valid = 1'b0;
        check_eq("bp_count", 32'(got), 32'd6);
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) extra++;
            tick();
        end
        check_eq("bp_no_dup", 32'(extra), 32'd0);
        sb_q.delete();

        // Reset with three transactions in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_a = va[c]; in_b = vb[c]; in_approx = vap[c];
            tick();
        end
        in_valid = 1'b0;
        check_eq("mid_full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) extra++;
            tick();
        end
        check_eq("mid_no_stale", 32'(extra), 32'd0);
        run_one(8);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
